// File: rtl/ps2_key_fifo.sv
// Purpose : decode PS/2 set-2 make codes into key values and queue them for the CPU in-port.
// Latency : push visible on status/num/count 1 cycle after code_stb; pop visible 1 cycle after control rises.
// Backpres: none upstream; keys arriving while full are dropped and flagged on sticky overflow.
//
// Ports:
//   clk, rst_n      board clock, asynchronous active-low reset
//   code, code_stb  ps2 shift pair ([7:0] newest, [15:8] previous) and its update strobe
//   control         CPU pop request level; each rising edge pops one entry
//   flush           synchronous clear of queue contents and overflow (held key kept)
//   status          queue non-empty
//   num             head entry value, 0 when empty
//   count           occupancy 0..DEPTH
//   overflow        sticky, set when a valid key is dropped because the queue is full
module ps2_key_fifo #(
    parameter int DEPTH     = 8,
    parameter int NUM_WIDTH = 4,
    parameter int HEX_MODE  = 0,
    parameter int REPEAT_EN = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                code,
    input  logic                       code_stb,
    input  logic                       control,
    input  logic                       flush,
    output logic                       status,
    output logic [NUM_WIDTH-1:0]       num,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 ovf;
    logic                 held_vld;
    logic [7:0]           held_code;
    logic                 control_q;

    logic                 map_vld;
    logic [NUM_WIDTH-1:0] map_val;
    logic                 is_break;
    logic                 is_ext;
    logic                 make_vld;
    logic                 is_repeat;
    logic                 push_key;
    logic                 pop_req;
    logic                 do_pop;
    logic                 do_push;
    logic                 full;
    logic                 empty;

    // Make-code lookup; hex letters only exist when HEX_MODE is set.
    always_comb begin
        map_vld = 1'b0;
        map_val = '0;
        case (code[7:0])
            8'h45: begin map_vld = 1'b1; map_val = NUM_WIDTH'(0);  end
            8'h16: begin map_vld = 1'b1; map_val = NUM_WIDTH'(1);  end
            8'h1E: begin map_vld = 1'b1; map_val = NUM_WIDTH'(2);  end
            8'h26: begin map_vld = 1'b1; map_val = NUM_WIDTH'(3);  end
            8'h25: begin map_vld = 1'b1; map_val = NUM_WIDTH'(4);  end
            8'h2E: begin map_vld = 1'b1; map_val = NUM_WIDTH'(5);  end
            8'h36: begin map_vld = 1'b1; map_val = NUM_WIDTH'(6);  end
            8'h3D: begin map_vld = 1'b1; map_val = NUM_WIDTH'(7);  end
            8'h3E: begin map_vld = 1'b1; map_val = NUM_WIDTH'(8);  end
            8'h46: begin map_vld = 1'b1; map_val = NUM_WIDTH'(9);  end
            8'h1C: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(10); end
            8'h32: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(11); end
            8'h21: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(12); end
            8'h23: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(13); end
            8'h24: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(14); end
            8'h2B: begin map_vld = (HEX_MODE != 0); map_val = NUM_WIDTH'(15); end
            default: begin map_vld = 1'b0; map_val = '0; end
        endcase
    end

    // Break is checked first so "F0 xx" never reaches the make path; a bare
    // F0/E0 byte or anything following an E0 prefix is dropped outright.
    assign is_break  = (code[15:8] == 8'hF0);
    assign is_ext    = (code[7:0] == 8'hF0) || (code[7:0] == 8'hE0) || (code[15:8] == 8'hE0);
    assign make_vld  = code_stb && !is_break && !is_ext && map_vld;
    assign is_repeat = held_vld && (held_code == code[7:0]);
    assign push_key  = make_vld && ((REPEAT_EN != 0) || !is_repeat);

    assign pop_req = control && !control_q;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = !flush && pop_req && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push = !flush && push_key && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            held_vld  <= 1'b0;
            held_code <= '0;
            control_q <= 1'b0;
        end else begin
            control_q <= control;

            if (code_stb && is_break) begin
                if (held_vld && (held_code == code[7:0])) begin
                    held_vld <= 1'b0;
                end
            end else if (make_vld) begin
                held_vld  <= 1'b1;
                held_code <= code[7:0];
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (do_push && !do_pop) begin
                    cnt <= cnt + CW'(1);
                end else if (do_pop && !do_push) begin
                    cnt <= cnt - CW'(1);
                end
                if (push_key && full && !do_pop) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; empty masking below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= map_val;
        end
    end

    assign status   = !empty;
    assign num      = empty ? '0 : mem[rd_ptr];
    assign count    = cnt;
    assign overflow = ovf;

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] code;
    logic        code_stb;
    logic        control;
    logic        flush;

    logic        status0, status1;
    logic [3:0]  num0, num1;
    logic [3:0]  count0, count1;
    logic        overflow0, overflow1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // dut0: decimal only, repeats filtered. dut1: hex keys, repeats enqueued.
    ps2_key_fifo #(.DEPTH(8), .NUM_WIDTH(4), .HEX_MODE(0), .REPEAT_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .code(code), .code_stb(code_stb),
        .control(control), .flush(flush), .status(status0), .num(num0),
        .count(count0), .overflow(overflow0)
    );

    ps2_key_fifo #(.DEPTH(8), .NUM_WIDTH(4), .HEX_MODE(1), .REPEAT_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .code(code), .code_stb(code_stb),
        .control(control), .flush(flush), .status(status1), .num(num1),
        .count(count1), .overflow(overflow1)
    );

    typedef struct {
        logic [15:0] code;
        int          cnt0;
        int          num0;
        int          cnt1;
        int          num1;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input int st, input int nm, input int ct, input int ov);
        check({name, " d0 status"},   int'(status0),   st);
        check({name, " d0 num"},      int'(num0),      nm);
        check({name, " d0 count"},    int'(count0),    ct);
        check({name, " d0 overflow"}, int'(overflow0), ov);
        check({name, " d1 status"},   int'(status1),   st);
        check({name, " d1 num"},      int'(num1),      nm);
        check({name, " d1 count"},    int'(count1),    ct);
        check({name, " d1 overflow"}, int'(overflow1), ov);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_code(input logic [15:0] c);
        code     = c;
        code_stb = 1'b1;
        tick();
        code_stb = 1'b0;
    endtask

    // Press and release, so the held key is clear afterwards.
    task automatic tap(input logic [7:0] c);
        apply_code({8'h00, c});
        apply_code({8'hF0, c});
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pop();
        control = 1'b1;
        tick();
        control = 1'b0;
        tick();
    endtask

    logic [7:0] keys [9];

    initial begin
        keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        //            code      c0 n0  c1 n1
        vecs[0]  = '{16'h0016, 1, 1,  1, 1};
        vecs[1]  = '{16'h0016, 0, 0,  1, 1};
        vecs[2]  = '{16'hF016, 0, 0,  0, 0};
        vecs[3]  = '{16'h0016, 1, 1,  1, 1};
        vecs[4]  = '{16'h001C, 0, 0,  1, 10};
        vecs[5]  = '{16'h0016, 0, 0,  1, 1};
        vecs[6]  = '{16'hE070, 0, 0,  0, 0};
        vecs[7]  = '{16'h00E0, 0, 0,  0, 0};
        vecs[8]  = '{16'h00F0, 0, 0,  0, 0};
        vecs[9]  = '{16'h0045, 1, 0,  1, 0};
        vecs[10] = '{16'h002B, 0, 0,  1, 15};
        vecs[11] = '{16'h0046, 1, 9,  1, 9};
        vecs[12] = '{16'h003D, 1, 7,  1, 7};
        vecs[13] = '{16'h0024, 0, 0,  1, 14};
        vecs[14] = '{16'h0000, 0, 0,  0, 0};
        vecs[15] = '{16'h1245, 1, 0,  1, 0};
        vecs[16] = '{16'hF045, 0, 0,  0, 0};
        vecs[17] = '{16'h0026, 1, 3,  1, 3};

        rst_n    = 1'b0;
        code     = '0;
        code_stb = 1'b0;
        control  = 1'b0;
        flush    = 1'b0;
        #12;
        check_both("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic push then pop.
        apply_code(16'h0016);
        check_both("push1", 1, 1, 1, 0);
        control = 1'b1;
        tick();
        control = 1'b0;
        check_both("pop1", 0, 0, 0, 0);
        apply_code(16'hF016);

        // Decode / repeat-filter table; each vector starts from an empty queue.
        for (int i = 0; i < 18; i++) begin
            do_flush();
            apply_code(vecs[i].code);
            check($sformatf("vec%0d d0 count", i),  int'(count0),  vecs[i].cnt0);
            check($sformatf("vec%0d d0 num", i),    int'(num0),    vecs[i].num0);
            check($sformatf("vec%0d d0 status", i), int'(status0), int'(vecs[i].cnt0 != 0));
            check($sformatf("vec%0d d1 count", i),  int'(count1),  vecs[i].cnt1);
            check($sformatf("vec%0d d1 num", i),    int'(num1),    vecs[i].num1);
        end

        // Break releases the held key; repeats without a break are filtered.
        do_flush();
        apply_code(16'h0045);
        apply_code(16'hF045);
        apply_code(16'h0045);
        check("rep break d0 count", int'(count0), 2);
        check("rep break d0 num",   int'(num0),   0);
        check("rep break d1 count", int'(count1), 2);
        apply_code(16'hF045);
        do_flush();
        apply_code(16'h0045);
        apply_code(16'h0045);
        apply_code(16'h0045);
        check("rep hold d0 count", int'(count0), 1);
        check("rep hold d1 count", int'(count1), 3);
        apply_code(16'hF045);

        // Overflow: nine keys into eight slots, drain in order, flush clears flag.
        do_flush();
        for (int i = 0; i < 9; i++) tap(keys[i]);
        check_both("ovf fill", 1, 1, 8, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf drain%0d d0 num", i), int'(num0), i + 1);
            check($sformatf("ovf drain%0d d1 num", i), int'(num1), i + 1);
            pop();
        end
        check_both("ovf empty", 0, 0, 0, 1);
        do_flush();
        check_both("ovf flush", 0, 0, 0, 0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 8; i++) tap(keys[i]);
        check_both("full", 1, 1, 8, 0);
        code     = 16'h002E;
        code_stb = 1'b1;
        control  = 1'b1;
        tick();
        code_stb = 1'b0;
        control  = 1'b0;
        check_both("full push+pop", 1, 2, 8, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp drain%0d d0 num", i), int'(num0), (i < 7) ? i + 2 : 5);
            check($sformatf("pp drain%0d d1 num", i), int'(num1), (i < 7) ? i + 2 : 5);
            pop();
        end
        check_both("pp empty", 0, 0, 0, 0);
        apply_code(16'hF02E);

        // Pop request on empty queue with simultaneous push.
        code     = 16'h0016;
        code_stb = 1'b1;
        control  = 1'b1;
        tick();
        code_stb = 1'b0;
        control  = 1'b0;
        check_both("empty push+pop", 1, 1, 1, 0);
        tick();
        apply_code(16'hF016);

        // Held control pops exactly once; then overfill and reset asynchronously.
        do_flush();
        tap(8'h16);
        tap(8'h1E);
        tap(8'h26);
        check_both("hold pre", 1, 1, 3, 0);
        control = 1'b1;
        repeat (20) tick();
        check_both("hold post", 1, 2, 2, 0);
        for (int i = 4; i < 9; i++) tap(keys[i]);
        tap(8'h45);
        tap(8'h16);
        check_both("hold overfill", 1, 2, 8, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_both("async reset", 0, 0, 0, 0);
        control = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_both("after reset", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Successor to the single-key scan-code decoder.
- Decodes PS/2 set-2 make codes into numeric key values and buffers them in a parametrised FIFO.
- Presents the head entry to the CPU through the existing status/control/num in-port handshake.
- Adds optional hex-key mode, typematic-repeat suppression, overflow reporting and flush.
- Sits between the ps2 receiver and the CPU `in`/`status`/`control` ports; runs on the undivided board clock.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- NUM_WIDTH, 4, width of the decoded key value; >= 4.
- HEX_MODE, 0, 1 = also accept keys A-F as values 10-15.
- REPEAT_EN, 0, 1 = enqueue typematic repeats; 0 = drop a make code equal to the held key.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- code  input  16  ps2 shift pair: [7:0] newest byte, [15:8] previous byte.
- code_stb  input  1  one-cycle pulse when `code` has just been updated with a new byte.
- control  input  1  CPU pop request, level; each 0->1 transition pops one entry.
- flush  input  1  synchronous clear of FIFO contents and overflow.
- status  output  1  1 when FIFO is non-empty.
- num  output  NUM_WIDTH  value of the head entry; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a valid key is dropped because the FIFO is full.

Behaviour:
- Reset (async, rst_n low): pointers = 0, count = 0, status = 0, num = 0, overflow = 0, held-key register = none, control edge register = 0. Memory contents don't care.
- Decode happens only on code_stb.
  - code[15:8] == 0xF0 (break): if code[7:0] equals the held key, clear the held key. Never enqueue.
  - code[7:0] == 0xF0 or 0xE0, or code[15:8] == 0xE0 (extended): ignored entirely.
  - Otherwise, make-code lookup: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - If HEX_MODE=1, also: 0x1C=10, 0x32=11, 0x21=12, 0x23=13, 0x24=14, 0x2B=15.
  - Unmapped codes are ignored and do not change the held key.
- Repeat filter:
  - A mapped make code sets the held key to that code.
  - If REPEAT_EN=0 and the code equals the held key, it is not enqueued.
- Push: a valid decoded key is written at the clk edge that samples code_stb = 1. status/num/count reflect it from the next cycle, i.e. 1-cycle latency.
- Pop:
  - A control edge detector registers control each cycle; pop_req = control & ~control_q.
  - A pop advances the read pointer at that edge; num shows the new head the following cycle.
  - Holding control high pops exactly once.
- num is taken combinationally from the registered read pointer and memory, masked to 0 when count == 0.
- Boundary conditions:
  - Push while count == DEPTH and no pop: entry dropped, overflow <= 1, count unchanged.
  - Push and pop in the same cycle while full: both performed, count stays DEPTH, overflow not set.
  - Push and pop in the same cycle at other occupancies: both performed, count unchanged.
  - Pop while empty: ignored; pointers and count unchanged. A simultaneous push still occurs.
  - Pointers wrap modulo DEPTH; count is tracked separately so full and empty are unambiguous.
  - flush (priority over push/pop that cycle): pointers = 0, count = 0, overflow = 0. Held key is retained.
  - Reset asserted mid-operation clears everything immediately and asynchronously. Release is synchronous to clk.
- count and the value range are never saturated silently: count width covers DEPTH exactly.

Test Plan:
1. Reset, then code_stb with code=0x0016 -> next cycle status=1, num=1, count=1. Then pulse control 0->1 -> next cycle status=0, num=0, count=0.
2. Sequence 0x0045, 0xF045 (break), 0x0045 with REPEAT_EN=0 -> count=2, num=0. Instead 0x0045, 0x0045, 0x0045 -> count=1. With REPEAT_EN=1, 0x0045 x3 -> count=3.
3. DEPTH=8: push keys 1..9 (released between each) -> count=8, overflow=1, eight pops yield 1..8 in order, then status=0. Flush -> overflow=0.
4. Fill to 8, then code_stb for key 5 in the same cycle as a control rising edge -> count stays 8, overflow=0, last popped entry is 5 after draining.
5. HEX_MODE=0: code 0x001C -> no push. HEX_MODE=1: 0x001C -> num=10. Code 0xE070 and 0x00E0 -> no push in either mode.
6. Hold control high for 20 cycles with 3 entries -> exactly 1 pop, count=2. Assert rst_n=0 mid-stream -> status=0, count=0, overflow=0 without waiting for a clk edge.
